// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter and sequencer sharing one single-port synchronous RAM
//   among NREQ requesters. A single transaction is in flight at any time:
//   IDLE -> ISSUE (one mem_en strobe) -> WAIT (MEM_LAT-1 cycles) -> ACK.
//   Back-to-back requests chain ACK -> ISSUE with no idle cycle.
//
// Handshake: a requester raises req[i] with we/addr/wdata stable until its
//   ack[i]. gnt[i] is high from ISSUE through ACK. ack[i] is a single-cycle
//   pulse. The request slice is captured at the edge that enters ISSUE, so
//   dropping req after the grant does not cancel the transaction.
//
// Configuration:
//   ARB_PRIO0_EN  defined: requester 0 beats the rotation whenever it
//                 requests, and such override wins do not move the pointer.
//                 Undefined: pure round-robin over all requesters.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   req, we               per-requester request level / write enable
//   addr, wdata           flat per-requester slices ([i*AW +: AW], [i*DW +: DW])
//   gnt, ack              one-hot grant (whole transaction) / completion pulse
//   rdata                 read data register, loaded from mem_rdata in ACK
//   mem_en, mem_we        RAM strobe (one cycle) and write enable
//   mem_addr, mem_wdata   RAM address / write data
//   mem_rdata             RAM read data, valid MEM_LAT cycles after mem_en
//   busy                  high whenever the FSM is not in IDLE
//   dbg_state             current FSM state (IDLE=0, ISSUE=1, WAIT=2, ACK=3)

module mem_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [DW-1:0]     rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int IW = $clog2(NREQ);
    // The wait counter only has to hold MEM_LAT-2.
    localparam int CW = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    typedef struct packed {
        logic          ovr;  // won through the requester-0 override
        logic [IW-1:0] idx;
    } pick_t;

    state_t        state;
    logic [IW-1:0] last;     // round-robin pointer: most recent RR winner
    logic [IW-1:0] cur_w;
    logic          cur_ovr;
    logic          cur_we;
    logic [CW-1:0] cnt;

    logic [IW-1:0] upd_ptr;
    logic [IW-1:0] arb_ptr;
    pick_t         nxt;
    logic          start;

    assign dbg_state = state;

    // Lowest offset from ptr+1 wins: scanning offsets downward lets the
    // nearest requester overwrite the farther ones.
    function automatic pick_t pick(input logic [NREQ-1:0] r, input logic [IW-1:0] ptr);
        pick_t res;
        int    k;
        res = '0;
        for (int i = NREQ; i >= 1; i--) begin
            k = (int'(ptr) + i) % NREQ;
            if (r[k]) res.idx = IW'(k);
        end
`ifdef ARB_PRIO0_EN
        if (r[0]) begin
            res.ovr = 1'b1;
            res.idx = '0;
        end
`endif
        return res;
    endfunction

    always_comb begin
        // In ACK the pointer is updated this edge, and the next winner is
        // chosen against that updated value.
        upd_ptr = cur_ovr ? last : cur_w;
        arb_ptr = (state == ACK) ? upd_ptr : last;
        nxt     = pick(req, arb_ptr);
        start   = ((state == IDLE) || (state == ACK)) && (|req);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= IW'(NREQ - 1);
            cur_w     <= '0;
            cur_ovr   <= 1'b0;
            cur_we    <= 1'b0;
            cnt       <= '0;
            gnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: ;
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (MEM_LAT > 1) begin
                        state <= WAIT;
                        cnt   <= CW'(MEM_LAT - 2);
                    end else begin
                        state <= ACK;
                        ack   <= gnt;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= ACK;
                        ack   <= gnt;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    // mem_rdata is valid in this cycle; rdata holds it afterwards.
                    if (!cur_we) rdata <= mem_rdata;
                    last  <= upd_ptr;
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // Launch a transaction; overrides the ACK -> IDLE defaults above.
            if (start) begin
                state     <= ISSUE;
                busy      <= 1'b1;
                cur_w     <= nxt.idx;
                cur_ovr   <= nxt.ovr;
                cur_we    <= we[nxt.idx];
                gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << nxt.idx;
                mem_en    <= 1'b1;
                mem_we    <= we[nxt.idx];
                mem_addr  <= addr[nxt.idx*AW +: AW];
                mem_wdata <= wdata[nxt.idx*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter (NREQ=4, AW=DW=8, MEM_LAT=3) with a
//   behavioural RAM. Table vectors cover single transactions from IDLE; the
//   hand-written sequences cover back-to-back rotation, a one-cycle request,
//   reset during WAIT and (when ARB_PRIO0_EN is defined) the priority override.

module tb_mem_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int LAT  = 3;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req, we, gnt, ack;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [DW-1:0]      rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]      mem_addr;
    logic               mem_en, mem_we, busy;
    logic [1:0]         dbg_state;

    mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .dbg_state(dbg_state)
    );

    // RAM model: unwritten words read as ~addr, except 8'h10 which holds 8'hA5.
    logic [7:0] ram [256];
    bit         written [256];
    logic [7:0] rpipe [LAT];

    function automatic logic [7:0] ram_rd(input logic [7:0] a);
        if (written[a]) return ram[a];
        if (a == 8'h10) return 8'hA5;
        return ~a;
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        rpipe[0] <= mem_en ? ram_rd(mem_addr) : 8'h00;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[LAT-1];

    // scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [NREQ-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every ack pulse must match the next expected grant in order.
    always @(negedge clk) begin
        if (reset && ack != '0) begin
            if (exp_q.size() == 0) check("ack_unexpected", 32'(ack), 32'h0);
            else check("ack_order", 32'(ack), 32'(exp_q.pop_front()));
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] w,
                         input logic [7:0] abase, input logic [7:0] dbase);
        req = r;
        we  = w;
        for (int i = 0; i < NREQ; i++) begin
            addr[i*AW +: AW]  = abase + 8'(i);
            wdata[i*DW +: DW] = dbase + 8'(i);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    typedef struct {
        logic [3:0] r;
        logic [3:0] w;
        logic [7:0] abase;
        logic [7:0] dbase;
        logic [3:0] exp_gnt;
        logic [7:0] exp_addr;
        logic [7:0] exp_wdata;
        logic       exp_we;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t       vecs [10];
    logic [3:0] ord [5];

    initial begin
        req = '0; we = '0; addr = '0; wdata = '0;

        // Winners chosen so the table holds with or without the override.
        vecs[0] = '{4'b0001, 4'b0000, 8'h10, 8'h00, 4'b0001, 8'h10, 8'h00, 1'b0, 8'hA5};
        vecs[1] = '{4'b0110, 4'b0000, 8'h20, 8'h00, 4'b0010, 8'h21, 8'h01, 1'b0, 8'hDE};
        vecs[2] = '{4'b1100, 4'b0100, 8'h1E, 8'h3A, 4'b0100, 8'h20, 8'h3C, 1'b1, 8'hDE};
        vecs[3] = '{4'b0010, 4'b0000, 8'h1F, 8'h00, 4'b0010, 8'h20, 8'h01, 1'b0, 8'h3C};
        vecs[4] = '{4'b1010, 4'b1000, 8'h30, 8'hC0, 4'b1000, 8'h33, 8'hC3, 1'b1, 8'h3C};
        vecs[5] = '{4'b1011, 4'b0000, 8'h33, 8'h00, 4'b0001, 8'h33, 8'h00, 1'b0, 8'hC3};
        vecs[6] = '{4'b1010, 4'b0000, 8'h40, 8'h00, 4'b0010, 8'h41, 8'h01, 1'b0, 8'hBE};
        vecs[7] = '{4'b1100, 4'b0000, 8'h50, 8'h00, 4'b0100, 8'h52, 8'h02, 1'b0, 8'hAD};
        vecs[8] = '{4'b0011, 4'b0001, 8'h60, 8'h90, 4'b0001, 8'h60, 8'h90, 1'b1, 8'hAD};
        vecs[9] = '{4'b0100, 4'b0000, 8'h5E, 8'h00, 4'b0100, 8'h60, 8'h02, 1'b0, 8'h90};

        // reset state
        reset = 1'b0;
        repeat (2) tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        reset = 1'b1;
        tick();

        // table: one transaction per vector, req dropped once granted
        for (int v = 0; v < 10; v++) begin
            drive(vecs[v].r, vecs[v].w, vecs[v].abase, vecs[v].dbase);
            exp_q.push_back(vecs[v].exp_gnt);
            tick();  // ISSUE
            check("v_mem_en", 32'(mem_en), 32'h1);
            check("v_gnt", 32'(gnt), 32'(vecs[v].exp_gnt));
            check("v_mem_we", 32'(mem_we), 32'(vecs[v].exp_we));
            check("v_mem_addr", 32'(mem_addr), 32'(vecs[v].exp_addr));
            check("v_mem_wdata", 32'(mem_wdata), 32'(vecs[v].exp_wdata));
            check("v_busy", 32'(busy), 32'h1);
            req = '0;
            for (int c = 1; c < LAT; c++) begin
                tick();  // WAIT
                check("v_wait_mem_en", 32'(mem_en), 32'h0);
                check("v_wait_gnt", 32'(gnt), 32'(vecs[v].exp_gnt));
                check("v_wait_ack", 32'(ack), 32'h0);
            end
            tick();  // ACK
            check("v_ack", 32'(ack), 32'(vecs[v].exp_gnt));
            check("v_ack_mem_we", 32'(mem_we), 32'h0);
            tick();  // back in IDLE
            check("v_rdata", 32'(rdata), 32'(vecs[v].exp_rdata));
            check("v_idle_busy", 32'(busy), 32'h0);
            check("v_idle_gnt", 32'(gnt), 32'h0);
        end

        // all four held: rotation with no idle gap, MEM_LAT+1 cycles apart
        do_reset();
`ifdef ARB_PRIO0_EN
        ord = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        for (int n = 0; n < 5; n++) exp_q.push_back(ord[n]);
        drive(4'b1111, 4'b0000, 8'h70, 8'h00);
        for (int t = 1; t <= 5 * (LAT + 1); t++) begin
            tick();
            check("rr_busy", 32'(busy), 32'h1);
            check("rr_mem_en", 32'(mem_en), ((t - 1) % (LAT + 1) == 0) ? 32'h1 : 32'h0);
            if (t >= LAT + 1 && (t - LAT - 1) % (LAT + 1) == 0)
                check("rr_ack", 32'(ack), 32'(ord[(t - LAT - 1) / (LAT + 1)]));
            else
                check("rr_no_ack", 32'(ack), 32'h0);
        end
        req = '0;
        tick();
        check("rr_idle_busy", 32'(busy), 32'h0);

        // req[3] pulsed for one cycle only
        drive(4'b1000, 4'b0000, 8'h80, 8'h00);
        exp_q.push_back(4'b1000);
        tick();
        req = '0;
        check("pulse_gnt_issue", 32'(gnt), 32'h8);
        for (int c = 1; c <= LAT; c++) begin
            tick();
            check("pulse_gnt_held", 32'(gnt), 32'h8);
        end
        check("pulse_ack", 32'(ack), 32'h8);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("pulse_idle_busy", 32'(busy), 32'h0);
            check("pulse_idle_ack", 32'(ack), 32'h0);
        end

        // reset asserted during WAIT: abandoned, no ack afterwards
        drive(4'b0010, 4'b0000, 8'h90, 8'h00);
        tick();  // ISSUE
        req = '0;
        tick();  // WAIT
        check("abort_in_wait", 32'(dbg_state), 32'h2);
        reset = 1'b0;
        #1;
        check("abort_gnt", 32'(gnt), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_mem_en", 32'(mem_en), 32'h0);
        check("abort_rdata", 32'(rdata), 32'h0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            tick();
            check("abort_no_ack", 32'(ack), 32'h0);
        end
        drive(4'b0100, 4'b0000, 8'hA0, 8'h00);
        exp_q.push_back(4'b0100);
        tick();
        check("abort_regrant", 32'(gnt), 32'h4);
        req = '0;
        repeat (LAT + 1) tick();

`ifdef ARB_PRIO0_EN
        // requester 0 arrives mid-transaction and takes the next slot
        drive(4'b0110, 4'b0000, 8'hB0, 8'h00);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0010);
        tick();
        check("prio_first", 32'(gnt), 32'h2);
        req = 4'b0111;
        repeat (LAT + 1) tick();
        check("prio_zero", 32'(gnt), 32'h1);
        req = 4'b0110;
        repeat (LAT + 1) tick();
        check("prio_resume2", 32'(gnt), 32'h4);
        repeat (LAT + 1) tick();
        check("prio_resume1", 32'(gnt), 32'h2);
        req = '0;
        repeat (LAT + 2) tick();
`endif

        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
